// File: rtl/shift_reg_bidir_pkg.sv
// Shared definitions for the bidirectional shift register.
// The mode is the concatenation {load, dr}.
package shift_reg_bidir_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned MODE_W        = 2;

  localparam logic [MODE_W-1:0] MODE_SHR      = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SHL      = 2'b01;
  localparam logic [MODE_W-1:0] MODE_LOAD     = 2'b10;
  localparam logic [MODE_W-1:0] MODE_LOAD_ALT = 2'b11;

endpackage

// File: rtl/shift_reg_cell.sv
// One bit of the shift register.
// It holds a 4:1 next-state mux feeding a flop with an async active-high clear.
module shift_reg_cell
  import shift_reg_bidir_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [MODE_W-1:0] mode,
  input  logic              right_in,  // bit i-1, or 0 at the LSB
  input  logic              left_in,   // bit i+1, or 0 at the MSB
  input  logic              in_bit,
  output logic              q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = q_q;
    case (mode)
      MODE_SHR:      q_d = left_in;
      MODE_SHL:      q_d = right_in;
      MODE_LOAD:     q_d = in_bit;
      MODE_LOAD_ALT: q_d = in_bit;
      default:       q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shift_reg_bidir.sv
// WIDTH-bit bidirectional shift register with parallel load and zero fill.
// The msb and lsb outputs export the edge bits of the stored word.
module shift_reg_bidir
  import shift_reg_bidir_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] IN,
  input  logic             load,
  input  logic             dr,
  output logic             msb,
  output logic             lsb,
  output logic [WIDTH-1:0] o
);

  logic [MODE_W-1:0] mode_c;
  logic [WIDTH-1:0]  o_q;
  logic [WIDTH+1:0]  ext_c;

  assign mode_c = {load, dr};

  // A zero is padded on each side, so the boundary cells shift in a constant 0.
  assign ext_c = {1'b0, o_q, 1'b0};

  for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_cell
    shift_reg_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .mode     (mode_c),
      .right_in (ext_c[gi]),
      .left_in  (ext_c[gi+2]),
      .in_bit   (IN[gi]),
      .q        (o_q[gi])
    );
  end

  assign o   = o_q;
  assign msb = o_q[WIDTH-1];
  assign lsb = o_q[0];

endmodule

// File: tb/tb_shift_reg_bidir.sv
// Directed self-checking bench for shift_reg_bidir.
module tb_shift_reg_bidir;

  logic       clk;
  logic       rst;
  logic [7:0] in_w;
  logic       load;
  logic       dr;
  logic       msb;
  logic       lsb;
  logic [7:0] o;

  int n_cmp;
  int n_err;

  shift_reg_bidir #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .IN   (in_w),
    .load (load),
    .dr   (dr),
    .msb  (msb),
    .lsb  (lsb),
    .o    (o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic exp_msb, input logic exp_lsb);
    check({tag, "_msb"}, {7'b0, msb}, {7'b0, exp_msb});
    check({tag, "_lsb"}, {7'b0, lsb}, {7'b0, exp_lsb});
  endtask

  initial begin
    logic [7:0] exp_v;
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    load  = 1'b0;
    dr    = 1'b0;
    in_w  = 8'h00;

    // The async clear must act before the first clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_async", o, 8'h00);
    step();
    check("rst_held", o, 8'h00);
    check_flags("rst", 1'b0, 1'b0);
    rst = 1'b0;
    step();
    check("rst_release_shr", o, 8'h00);

    // Load, then shift right.
    in_w = 8'b1100_1100; load = 1'b1;
    step();
    check("load_cc", o, 8'b1100_1100);
    load = 1'b0; dr = 1'b0;
    step();
    check("shr1", o, 8'b0110_0110);
    step();
    check("shr2", o, 8'b0011_0011);
    step();
    check("shr3", o, 8'b0001_1001);
    step();
    check("shr4", o, 8'b0000_1100);
    check_flags("shr4", 1'b0, 1'b0);

    // Shift left.
    dr = 1'b1;
    step();
    check("shl1", o, 8'b0001_1000);
    step();
    check("shl2", o, 8'b0011_0000);
    step();
    check("shl3", o, 8'b0110_0000);
    step();
    check("shl4", o, 8'b1100_0000);
    check_flags("shl4", 1'b1, 1'b0);

    // Reload, then mixed directions.
    in_w = 8'b0011_0011; load = 1'b1; dr = 1'b0;
    step();
    check("load_33", o, 8'b0011_0011);
    check_flags("load_33", 1'b0, 1'b1);
    load = 1'b0; dr = 1'b1;
    step();
    check("mix_shl1", o, 8'b0110_0110);
    step();
    check("mix_shl2", o, 8'b1100_1100);
    step();
    check("mix_shl3", o, 8'b1001_1000);
    check_flags("mix_shl3", 1'b1, 1'b0);
    dr = 1'b0;
    step();
    check("mix_shr1", o, 8'b0100_1100);
    step();
    check("mix_shr2", o, 8'b0010_0110);

    // Load has priority over dr.
    in_w = 8'b1010_1010; load = 1'b1; dr = 1'b0;
    step();
    check("load_aa", o, 8'b1010_1010);
    in_w = 8'b0000_1111; load = 1'b1; dr = 1'b1;
    step();
    check("prio_load_dr", o, 8'b0000_1111);
    check_flags("prio", 1'b0, 1'b1);

    // Assert the async reset between two edges while shifting left.
    in_w = 8'b1111_0000; load = 1'b1; dr = 1'b0;
    step();
    check("load_f0", o, 8'b1111_0000);
    load = 1'b0; dr = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_shift", o, 8'h00);
    check_flags("rst_mid", 1'b0, 1'b0);
    #1 rst = 1'b0;
    step();
    check("post_rst_shl", o, 8'h00);
    in_w = 8'b0000_0001; load = 1'b1;
    step();
    check("load_01", o, 8'b0000_0001);
    load = 1'b0; dr = 1'b1;
    step();
    check("shl_01", o, 8'b0000_0010);

    // Eight right shifts of all ones drain the register to zero.
    in_w = 8'hFF; load = 1'b1; dr = 1'b0;
    step();
    check("load_ff", o, 8'hFF);
    load = 1'b0; dr = 1'b0;
    exp_v = 8'hFF;
    for (int k = 1; k <= 8; k++) begin
      exp_v = {1'b0, exp_v[7:1]};
      step();
      check($sformatf("drain_%0d", k), o, exp_v);
    end
    step();
    check("drain_extra", o, 8'h00);
    check_flags("drain", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
